fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader_pkg.sv | 22 ++
 rtl/fifo_stream_reader_if.sv | 23 ++
 rtl/fifo_stream_reader.sv | 95 +++++++++
 tb/tb_fifo_stream_reader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants for the FIFO-to-stream reader: occupancy encodings and the
// read-credit helper used to decide when a new FIFO read may be issued.
package fifo_stream_reader_pkg;

    localparam int BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_e;

    // Words held once this cycle settles must leave room for one more read.
    function automatic logic credit_ok(input logic [1:0] occ,
                                       input logic       in_flight,
                                       input logic       pop);
        logic [2:0] committed;
        committed = {1'b0, occ} + {2'b00, in_flight} - {2'b00, pop};
        return committed < 3'(BUF_DEPTH);
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read side plus outgoing valid/ready stream, bundled for the reader.
// master = the reader block, slave = the FIFO/sink environment around it.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 36
);
    logic                  fifo_empty;
    logic                  fifo_oe;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [1:0]            occupancy;

    modport master (
        input  fifo_empty, fifo_dout, m_ready,
        output fifo_oe, m_valid, m_data, occupancy
    );

    modport slave (
        output fifo_empty, fifo_dout, m_ready,
        input  fifo_oe, m_valid, m_data, occupancy
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency sync FIFO into a registered valid/ready stream
// through a 2-entry skid buffer, sustaining one word per cycle.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 36
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    fifo_stream_reader_if.master  bus
);

    occ_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  in_flight_q;

    logic                  m_valid;
    logic                  pop;
    logic                  push;
    logic                  rd_en;

    assign m_valid = (state_q != ST_EMPTY);
    assign pop     = ce && m_valid && bus.m_ready;
    assign push    = ce && in_flight_q;

    // Only issue a read if the word it returns next cycle is guaranteed a slot.
    assign rd_en = ce && !rst && !bus.fifo_empty &&
                   credit_ok(state_q, in_flight_q, pop);

    assign bus.fifo_oe   = rd_en;
    assign bus.m_valid   = m_valid;
    assign bus.m_data    = head_q;
    assign bus.occupancy = state_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    head_d  = bus.fifo_dout;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    head_d = bus.fifo_dout;
                end else if (push) begin
                    tail_d  = bus.fifo_dout;
                    state_d = ST_TWO;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // Tail slides forward on a pop; a concurrent push refills it.
                if (pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = bus.fifo_dout;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            in_flight_q <= 1'b0;
        end else if (ce) begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            in_flight_q <= rd_en;
        end
    end

    // The credit check must make an unpaired push into a full buffer impossible.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst)
        (push && state_q == ST_TWO) |-> pop
    ) else $error("fifo_stream_reader: push into full buffer without pop");

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench: a behavioural sync FIFO feeds the reader, a negedge
// monitor checks every stream transfer and the hold-while-stalled rule.
module tb_fifo_stream_reader;

    localparam int DW = 36;

    logic clk = 1'b0;
    logic rst;
    logic ce;
    always #5 clk = ~clk;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus();

    fifo_stream_reader #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int oe_total = 0;

    // Behavioural sync FIFO: oe this cycle -> dout valid next cycle.
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] fq[$];
    int            fcnt = 0;

    assign bus.fifo_empty = (fcnt == 0);

    always @(posedge clk) begin
        if (rst) begin
            fq.delete();
            fcnt <= 0;
        end else begin
            if (bus.fifo_oe) bus.fifo_dout <= fq.pop_front();
            if (wr_en) fq.push_back(wr_data);
            fcnt <= fcnt + int'(wr_en) - int'(bus.fifo_oe);
        end
    end

    logic [DW-1:0] exp_q[$];

    always @(negedge clk) begin
        if (bus.fifo_oe) oe_total++;
    end

    // Monitor: sample mid-cycle; what is seen here is what the next edge acts on.
    logic [DW-1:0] prev_data = '0;
    logic          prev_hold = 1'b0;
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                checks++;
                if (!bus.m_valid || bus.m_data !== prev_data) begin
                    errors++;
                    $display("FAIL hold: m_valid=%b m_data=%h required m_valid=1 m_data=%h",
                             bus.m_valid, bus.m_data, prev_data);
                end
            end
            if (bus.m_valid && bus.m_ready && ce) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra: got %h with nothing expected", bus.m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.m_data !== e) begin
                        errors++;
                        $display("FAIL stream_data: got %h expected %h", bus.m_data, e);
                    end
                end
            end
            prev_hold = bus.m_valid && !(bus.m_ready && ce);
            prev_data = bus.m_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic write_word(input logic [DW-1:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        exp_q.push_back(w);
        step();
        wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while ((exp_q.size() != 0 || bus.m_valid) && n < max_cycles) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || bus.m_valid) begin
            errors++;
            $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        int oe0;
        rst        = 1'b1;
        ce         = 1'b1;
        bus.m_ready = 1'b0;
        repeat (3) step();
        chk("rst_m_valid",   64'(bus.m_valid),   64'd0);
        chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
        chk("rst_fifo_oe",   64'(bus.fifo_oe),   64'd0);
        chk("rst_m_data",    64'(bus.m_data),    64'd0);
        rst = 1'b0;
        step();
        chk("post_rst_occupancy", 64'(bus.occupancy), 64'd0);

        // Three words, sink always ready: 2-cycle latency then back-to-back.
        bus.m_ready = 1'b1;
        write_word(36'h1);
        chk("lat0_m_valid", 64'(bus.m_valid), 64'd0);
        write_word(36'h2);
        chk("lat1_m_valid", 64'(bus.m_valid), 64'd0);
        write_word(36'h3);
        chk("lat2_m_valid", 64'(bus.m_valid), 64'd1);
        chk("seq_data0",    64'(bus.m_data),  64'h1);
        step();
        chk("seq_valid1",   64'(bus.m_valid), 64'd1);
        chk("seq_data1",    64'(bus.m_data),  64'h2);
        step();
        chk("seq_valid2",   64'(bus.m_valid), 64'd1);
        chk("seq_data2",    64'(bus.m_data),  64'h3);
        wait_drain(20);
        step();

        // Stalled sink: only two reads may be issued, head holds word0.
        bus.m_ready = 1'b0;
        step();
        oe0 = oe_total;
        for (int i = 0; i < 8; i++) write_word(36'h100 + 36'(i));
        repeat (10) step();
        chk("stall_oe_pulses", 64'(oe_total - oe0), 64'd2);
        chk("stall_occupancy", 64'(bus.occupancy),  64'd2);
        chk("stall_head",      64'(bus.m_data),     64'h100);
        bus.m_ready = 1'b1;
        wait_drain(40);

        // Alternating ready while streaming 16 words.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.m_ready = ~bus.m_ready;
            write_word(36'h200 + 36'(i));
        end
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) begin
            bus.m_ready = ~bus.m_ready;
            step();
        end
        bus.m_ready = 1'b1;
        wait_drain(10);

        // Clock enable dropped with a read in flight.
        write_word(36'h300);
        write_word(36'h301);
        ce = 1'b0;
        #1;
        chk("ce_low_fifo_oe", 64'(bus.fifo_oe), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ce_low_occupancy", 64'(bus.occupancy), 64'd0);
            chk("ce_low_m_valid",   64'(bus.m_valid),   64'd0);
            chk("ce_low_oe",        64'(bus.fifo_oe),   64'd0);
        end
        ce = 1'b1;
        step();
        chk("ce_resume_valid", 64'(bus.m_valid), 64'd1);
        chk("ce_resume_data",  64'(bus.m_data),  64'h300);
        wait_drain(20);

        // Reset with a full buffer discards everything.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) write_word(36'h400 + 36'(i));
        repeat (4) step();
        chk("prerst_occupancy", 64'(bus.occupancy), 64'd2);
        rst = 1'b1;
        #1;
        chk("rst_blocks_oe", 64'(bus.fifo_oe), 64'd0);
        step();
        exp_q.delete();
        chk("rst_full_m_valid",   64'(bus.m_valid),   64'd0);
        chk("rst_full_occupancy", 64'(bus.occupancy), 64'd0);
        chk("rst_full_fifo_oe",   64'(bus.fifo_oe),   64'd0);
        chk("rst_full_m_data",    64'(bus.m_data),    64'd0);
        rst = 1'b0;
        step();
        chk("after_rst_m_valid", 64'(bus.m_valid), 64'd0);

        // Long random run: random writes, ready and clock enable.
        for (int w = 0; w < 10000; ) begin
            ce          = ($urandom_range(9) != 0);
            bus.m_ready = 1'($urandom_range(1));
            if ($urandom_range(3) != 0 && fcnt < 64) begin
                write_word(36'($urandom) ^ {4'h5, 32'(w)});
                w++;
            end else begin
                step();
            end
        end
        ce          = 1'b1;
        bus.m_ready = 1'b1;
        wait_drain(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
